bf16_div_seq: RTL and testbench

- Multi-cycle bfloat16 divider for the FPU. It is the inverse operation of the single-cycle bfloat16 multiplier.
- Computes result_o = a_i / b_i with a radix-2 restoring division, one quotient bit per cycle.
- Uses a valid/ready handshake on both input and output, so it sits alongside the combinational FPU ops behind the same issue logic.
- NaN, infinity and zero handling and encodings match the FPU multiplier.

---
 rtl/bf16_div_seq.sv | 147 ++++++++++++++
 tb/tb_bf16_div_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bf16_div_seq.sv
// bf16_div_seq: multi-cycle bfloat16 divider.
// Radix-2 restoring division, one quotient bit per cycle, with valid/ready
// handshakes on both sides. Special operands resolve through the NORM slot so
// that their result appears one edge after acceptance.
module bf16_div_seq #(
    parameter int          QBITS     = 10,
    parameter logic [15:0] CANON_NAN = 16'h7FC0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_reg;
    logic [3:0]        cnt_reg;
    logic [QBITS-1:0]  q_reg;
    logic [8:0]        rem_reg;
    logic [7:0]        mb_reg;
    logic              sign_reg;
    logic signed [9:0] e_reg;
    logic              spec_reg;
    logic [15:0]       spec_res_reg;
    logic [15:0]       result_reg;

    // Special-case detection on the incoming operands; bit 16 flags a special.
    function automatic logic [16:0] special_f(input logic [15:0] a, input logic [15:0] b);
        logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, s;
        a_nan  = (&a[14:7]) && (|a[6:0]);
        a_inf  = (&a[14:7]) && !(|a[6:0]);
        a_zero = !(|a[14:7]);
        b_nan  = (&b[14:7]) && (|b[6:0]);
        b_inf  = (&b[14:7]) && !(|b[6:0]);
        b_zero = !(|b[14:7]);
        s      = a[15] ^ b[15];
        if (a_nan || b_nan)        return {1'b1, CANON_NAN};
        else if (a_inf && b_inf)   return {1'b1, CANON_NAN};
        else if (a_zero && b_zero) return {1'b1, CANON_NAN};
        else if (a_inf)            return {1'b1, s, 15'h7F80};
        else if (b_zero)           return {1'b1, s, 15'h7F80};
        else if (a_zero)           return {1'b1, 16'h0000};
        else if (b_inf)            return {1'b1, 16'h0000};
        else                       return {1'b0, 16'h0000};
    endfunction

    logic [16:0] spec_in;
    assign spec_in = special_f(a_i, b_i);

    // One restoring-division step on the current remainder.
    logic       ge;
    logic [8:0] rem_sub;
    logic [8:0] rem_next;
    always_comb begin
        ge       = (rem_reg >= {1'b0, mb_reg});
        rem_sub  = ge ? (rem_reg - {1'b0, mb_reg}) : rem_reg;
        rem_next = {rem_sub[7:0], 1'b0};
    end

    // Normalize, round to nearest even, and range-check the finished quotient.
    logic signed [9:0] e_norm;
    logic signed [9:0] e_fin;
    logic [6:0]        mant;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [7:0]        mant_sum;
    logic [15:0]       norm_res;
    always_comb begin
        if (q_reg[QBITS-1]) begin
            mant   = q_reg[QBITS-2:QBITS-8];
            guard  = q_reg[1];
            sticky = q_reg[0] | (|rem_reg);
            e_norm = e_reg;
        end else begin
            mant   = q_reg[QBITS-3:QBITS-9];
            guard  = q_reg[0];
            sticky = |rem_reg;
            e_norm = e_reg - 10'sd1;
        end
        inc      = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {7'b0, inc};
        e_fin    = mant_sum[7] ? (e_norm + 10'sd1) : e_norm;
        if (e_fin >= 10'sd255)    norm_res = {sign_reg, 15'h7F80};
        else if (e_fin <= 10'sd0) norm_res = 16'h0000;
        else                      norm_res = {sign_reg, e_fin[7:0], mant_sum[6:0]};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            q_reg        <= '0;
            rem_reg      <= '0;
            mb_reg       <= '0;
            sign_reg     <= 1'b0;
            e_reg        <= '0;
            spec_reg     <= 1'b0;
            spec_res_reg <= '0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (valid_i) begin
                        rem_reg      <= {2'b01, a_i[6:0]};
                        mb_reg       <= {1'b1, b_i[6:0]};
                        sign_reg     <= a_i[15] ^ b_i[15];
                        e_reg        <= $signed({2'b00, a_i[14:7]}) - $signed({2'b00, b_i[14:7]}) + 10'sd127;
                        spec_reg     <= spec_in[16];
                        spec_res_reg <= spec_in[15:0];
                        q_reg        <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= spec_in[16] ? S_NORM : S_DIV;
                    end
                end
                S_DIV: begin
                    q_reg   <= {q_reg[QBITS-2:0], ge};
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'(QBITS - 1)) state_reg <= S_NORM;
                end
                S_NORM: begin
                    result_reg <= spec_reg ? spec_res_reg : norm_res;
                    state_reg  <= S_DONE;
                end
                default: begin
                    if (ready_i) state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (state_reg == S_IDLE);
    assign valid_o  = (state_reg == S_DONE);
    assign result_o = result_reg;

endmodule

// File: tb/tb_bf16_div_seq.sv
// Directed self-checking bench for bf16_div_seq.
module tb_bf16_div_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [15:0] result_o;

    int passed = 0;
    int total  = 0;

    bf16_div_seq dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one operation, wait (bounded) for the result, check value and latency,
    // then hold the result for 'hold' cycles before accepting it.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int lat, input bit noise, input int hold);
        int n;
        int bad;
        logic [15:0] held;
        @(negedge clk_i);
        chk({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
        valid_i = 1'b1; a_i = a; b_i = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n = 0;
        while (valid_o !== 1'b1 && n < 40) begin
            if (noise && n >= 2 && n <= 5) begin
                valid_i = 1'b1; a_i = 16'h4000; b_i = 16'h3F80;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk_i); #1;
            n++;
        end
        valid_i = 1'b0;
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, {16'b0, result_o}, {16'b0, exp});
        $display("op %s: %h / %h -> %h (expect %h) latency %0d", tag, a, b, result_o, exp, n);
        if (hold > 0) begin
            bad = 0;
            held = result_o;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk_i); #1;
                if (valid_o !== 1'b1 || result_o !== held || ready_o !== 1'b0) bad++;
            end
            chk({tag, "_hold_bad_cycles"}, bad, 0);
            chk({tag, "_hold_res"}, {16'b0, result_o}, {16'b0, exp});
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        chk({tag, "_drop"}, {30'b0, valid_o, ready_o}, {30'b0, 2'b01});
    endtask

    initial begin
        int bad;
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_result", {16'b0, result_o}, 32'd0);
        rst_ni = 1'b1;

        // Normal arithmetic
        run("one_div_one",   16'h3F80, 16'h3F80, 16'h3F80, 11, 1'b0, 0);
        run("one_div_three", 16'h3F80, 16'h4040, 16'h3EAB, 11, 1'b0, 0);
        run("six_div_m2",    16'h40C0, 16'hC000, 16'hC040, 11, 1'b0, 0);

        // Special operands
        run("pos_div_zero",  16'h3F80, 16'h0000, 16'h7F80, 1, 1'b0, 0);
        run("neg_div_zero",  16'hBF80, 16'h0000, 16'hFF80, 1, 1'b0, 0);
        run("zero_div_zero", 16'h0000, 16'h0000, 16'h7FC0, 1, 1'b0, 0);
        run("inf_div_inf",   16'h7F80, 16'h7F80, 16'h7FC0, 1, 1'b0, 0);
        run("nan_div_one",   16'h7FC1, 16'h3F80, 16'h7FC0, 1, 1'b0, 0);
        run("one_div_inf",   16'h3F80, 16'h7F80, 16'h0000, 1, 1'b0, 0);

        // Range limits and the q[9]=0 normalization path
        run("overflow",      16'h7F00, 16'h0080, 16'h7F80, 11, 1'b0, 0);
        run("underflow",     16'h0080, 16'h7F00, 16'h0000, 11, 1'b0, 0);
        run("q9_zero",       16'h3F80, 16'h3F81, 16'h3F7E, 11, 1'b0, 0);

        // Backpressure hold
        run("backpressure",  16'h3F80, 16'h4040, 16'h3EAB, 11, 1'b0, 20);

        // valid_i during DIV must be ignored, and no extra result may follow
        run("noise_in_div",  16'h3F80, 16'h4040, 16'h3EAB, 11, 1'b1, 0);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i); #1;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) bad++;
        end
        chk("noise_no_extra_result", bad, 0);

        // Reset in the middle of DIV aborts the operation
        @(negedge clk_i);
        valid_i = 1'b1; a_i = 16'h3F80; b_i = 16'h4040;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        chk("midrst_valid", {31'b0, valid_o}, 32'd0);
        chk("midrst_ready", {31'b0, ready_o}, 32'd1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i); #1;
            if (valid_o !== 1'b0) bad++;
        end
        chk("midrst_no_result", bad, 0);
        run("after_reset",   16'h4000, 16'h4000, 16'h3F80, 11, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
